debounced_fifo: RTL and testbench
=================================

// Module: debounced_fifo
// PURPOSE
//  Parametrised button-driven FIFO for board bring-up: two bouncy push-buttons push/pop words of a
//  DATA_W-bit switch bus into a 2**ADDR_W deep buffer.
//  Head word, occupancy, full/empty and sticky error flags go to board LEDs/display.
//  Generalises the fixed 8-bit button FIFO with configurable width, depth and debounce length,
//  plus occupancy and overflow/underflow reporting.
// PARAMETERS
//  DATA_W     8   width of stored word
//  ADDR_W     3   log2 of depth (depth = 2**ADDR_W)
//  DB_CYCLES  4   consecutive stable clocks required to accept a button level change (>=2)
// PORTS
//  clk         in   1         system clock, rising edge
//  clr         in   1         asynchronous active-high reset
//  button_wrd  in   1         raw write button, asynchronous, bouncy
//  button_red  in   1         raw read button, asynchronous, bouncy
//  data        in   DATA_W    word captured on accepted write
//  r_data      out  DATA_W    head-of-FIFO word (first-word fall-through)
//  write       out  1         one-cycle pulse: debounced write press
//  read        out  1         one-cycle pulse: debounced read press
//  full        out  1         count == 2**ADDR_W
//  empty       out  1         count == 0
//  count       out  ADDR_W+1  current occupancy
//  ovf         out  1         sticky: write pulse rejected while full
//  udf         out  1         sticky: read pulse rejected while empty
//  sseg        out  8         seven-segment pattern of r_data[3:0], active-low
// BEHAVIOUR
//  Reset (clr=1, async): pointers, count, debounce state, ovf, udf = 0.
//   empty=1, full=0, write=read=0, r_data=0.
//   Memory contents undefined but never visible while empty (r_data forced 0 when empty).
//  Debounce (per button):
//   - 2-FF synchroniser, then counter cnt.
//   - sync==level: cnt<=0.
//   - sync!=level: cnt increments; when cnt==DB_CYCLES-1, level<=sync and cnt<=0.
//   - Any bounce back clears cnt; glitches shorter than DB_CYCLES clocks never reach level.
//  Pulse: write = level_w & ~level_w_d (level_w_d = level_w delayed 1 clk); same for read.
//   One pulse per press; release generates nothing.
//   Holding a button produces no repeats.
//  Latency: stable press -> pulse high 2+DB_CYCLES+1 clocks after first sampling edge.
//   FIFO state commits on the edge ending the pulse cycle.
//  Write pulse, !full: mem[wptr]<=data, wptr++. Read pulse, !empty: rptr++.
//   Pointers wrap modulo 2**ADDR_W.
//   count is ADDR_W+1 bits; it is maintained as a register, not derived from the pointers.
//  Acceptance is evaluated on the pre-edge state.
//  Simultaneous write+read pulse:
//   - neither full nor empty: both happen, count unchanged.
//   - full: both happen, count stays full, ovf not set.
//   - empty: write happens, read rejected, udf set, count=1.
//  Rejected write (full, no read): memory/pointers untouched, ovf<=1.
//   Rejected read (empty): udf<=1.
//  ovf/udf clear only on clr.
//  r_data = mem[rptr] combinationally; updates the cycle after any accepted read or first write.
// CONFIGURATION
//  SEVEN_SEG_EN defined:
//   - sseg[6:0] = gfedcba hex decode of r_data[3:0], active-low; sseg[7] = dp = 1 (off).
//   - When empty: 8'hBF (dash).
//  SEVEN_SEG_EN undefined: sseg tied to 8'hFF (all segments off), no decode logic.
// STRUCTURE
//  Package dfifo_pkg:
//   - constants SSEG_BLANK=8'hFF, SSEG_DASH=8'hBF.
//   - function hex_to_sseg(input [3:0]) returning the 8-bit pattern.
//  Sub-module btn_debounce (#DB_CYCLES): sync + counter + edge pulse; instantiated twice.
//  Top: storage array, pointers, count, flags, sseg mux.
// TESTING (DATA_W=8, ADDR_W=3, DB_CYCLES=4, clk 20 ns)
//  1 Bounce: button_wrd high 4 ns, low 8 ns, high 8 ns, then held 200 ns
//     -> exactly one write pulse; count=1, r_data=data.
//  2 Fill: 8 presses with data 0..7 -> count=8, full=1, r_data=8'h00; 9th press data=8'h55
//     -> ovf=1, count=8, contents unchanged.
//  3 Drain: 8 read presses -> r_data steps 1..7 then empty=1, r_data=0; 9th read
//     -> udf=1, count=0. With SEVEN_SEG_EN: sseg=8'hB0 when head=3, 8'hBF when empty.
//  4 Simultaneous press, FIFO empty, data=8'hA5 -> count=1, r_data=8'hA5, udf=1.
//     Same while full -> count=8, ovf=0, head advances.
//  5 Wrap: 6 writes, 6 reads, 4 writes (values 10..13) -> reads return 10..13 in order.
//  6 Reset mid-press: assert clr while cnt>0 and count=3 -> immediately empty=1, count=0,
//     ovf=udf=0. Button held across release -> no pulse until a full DB_CYCLES stable period.

Source files
------------

// File: rtl/dfifo_pkg.sv
// Shared constants and seven-segment decode for the button FIFO.
// Patterns are active-low gfedcba with dp in bit 7.
package dfifo_pkg;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;

  function automatic logic [7:0] hex_to_sseg(
    input logic [3:0] nib
  );
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debounced_fifo_btn_debounce.sv
// Button synchroniser, stability counter and press-edge pulse.
// A level change is accepted after DB_CYCLES consecutive stable clocks.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;

  // two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn};
  end

  // stability counter; any bounce back to level restarts it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= sync_q[1];
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // delayed level for rising-edge detection
  always_ff @(posedge clk or posedge clr) begin
    if (clr) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/debounced_fifo.sv
// Button-driven FWFT FIFO with occupancy and sticky ovf/udf flags.
// Define SEVEN_SEG_EN to drive a hex decode of the head word on sseg.
module debounced_fifo
  import dfifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              button_wrd,
  input  logic              button_red,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] r_data,
  output logic              write,
  output logic              read,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  output logic [7:0]        sseg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_ok;
  logic              rd_ok;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_w (
    .clk   (clk),
    .clr   (clr),
    .btn   (button_wrd),
    .pulse (write)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
    .clk   (clk),
    .clr   (clr),
    .btn   (button_red),
    .pulse (read)
  );

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = count[ADDR_W];
  assign empty = (count == '0);

  // a read frees a slot in the same cycle, so write while full is fine then
  assign wr_ok = write & (~full | read);
  assign rd_ok = read & ~empty;

  // storage has no reset; it is hidden while empty
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= data;
  end

  // pointers, occupancy and sticky error flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_W'(1);
      if (rd_ok) rptr <= rptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(wr_ok)
                     - (ADDR_W+1)'(rd_ok);
      if (write & full & ~read) ovf <= 1'b1;
      if (read & empty)         udf <= 1'b1;
    end
  end

  // first-word fall-through head, forced to zero while empty
  always_comb begin
    r_data = '0;
    if (!empty) r_data = mem[rptr];
  end

  // display drive for the head nibble
  always_comb begin
`ifdef SEVEN_SEG_EN
    sseg = empty ? SSEG_DASH : hex_to_sseg(r_data[3:0]);
`else
    sseg = SSEG_BLANK;
`endif
  end

endmodule

// File: tb/tb_debounced_fifo.sv
// Directed bench for debounced_fifo: bounce, fill, drain, simultaneous,
// wrap and mid-press reset, checked with immediate assertions.
module tb_debounced_fifo;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       button_wrd = 1'b0;
  logic       button_red = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] r_data;
  logic       write;
  logic       read;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       udf;
  logic [7:0] sseg;

  int total = 0;
  int bad   = 0;
  int nw    = 0;
  int nr    = 0;
  int snap;

  debounced_fifo #(
    .DATA_W(8), .ADDR_W(3), .DB_CYCLES(4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .button_wrd (button_wrd),
    .button_red (button_red),
    .data       (data),
    .r_data     (r_data),
    .write      (write),
    .read       (read),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ovf        (ovf),
    .udf        (udf),
    .sseg       (sseg)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (write) nw++;
    if (read)  nr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  task automatic press(input logic w, input logic r,
                       input logic [7:0] d);
    data = d;
    button_wrd = w;
    button_red = r;
    cyc(12);
    button_wrd = 1'b0;
    button_red = 1'b0;
    cyc(12);
  endtask

  initial begin
    // reset state
    #5;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rdata", r_data, 0);
    check("rst_flags", {ovf, udf, write, read}, 0);
`ifdef SEVEN_SEG_EN
    check("rst_sseg", sseg, 8'hBF);
`else
    check("rst_sseg", sseg, 8'hFF);
`endif
    cyc(2);
    clr = 1'b0;
    cyc(1);

    // 1 bounce
    data = 8'h3C;
    snap = nw;
    button_wrd = 1'b1; #4;
    button_wrd = 1'b0; #8;
    button_wrd = 1'b1; #8;
    #200;
    button_wrd = 1'b0;
    cyc(12);
    check("bounce_pulses", nw - snap, 1);
    check("bounce_count", count, 1);
    check("bounce_rdata", r_data, 8'h3C);

    // 2 fill
    do_reset();
    for (int i = 0; i < 8; i++) press(1, 0, 8'(i));
    check("fill_count", count, 8);
    check("fill_full", full, 1);
    check("fill_rdata", r_data, 8'h00);
    check("fill_ovf0", ovf, 0);
    press(1, 0, 8'h55);
    check("ovf_set", ovf, 1);
    check("ovf_count", count, 8);
    check("ovf_head", r_data, 8'h00);

    // 3 drain
    for (int i = 1; i < 8; i++) begin
      press(0, 1, 8'h00);
      check($sformatf("drain_head%0d", i), r_data, i);
`ifdef SEVEN_SEG_EN
      if (i == 3) check("sseg_3", sseg, 8'hB0);
`endif
    end
    press(0, 1, 8'h00);
    check("drain_empty", empty, 1);
    check("drain_rdata", r_data, 0);
    check("drain_udf0", udf, 0);
`ifdef SEVEN_SEG_EN
    check("sseg_dash", sseg, 8'hBF);
`else
    check("sseg_off", sseg, 8'hFF);
`endif
    press(0, 1, 8'h00);
    check("udf_set", udf, 1);
    check("udf_count", count, 0);

    // 4 simultaneous
    do_reset();
    check("clr_udf", udf, 0);
    press(1, 1, 8'hA5);
    check("sim_e_count", count, 1);
    check("sim_e_rdata", r_data, 8'hA5);
    check("sim_e_udf", udf, 1);
    for (int i = 1; i < 8; i++) press(1, 0, 8'(8'h10 + i));
    check("sim_f_full", full, 1);
    press(1, 1, 8'hEE);
    check("sim_f_count", count, 8);
    check("sim_f_ovf", ovf, 0);
    check("sim_f_head", r_data, 8'h11);

    // 5 wrap
    do_reset();
    for (int i = 0; i < 6; i++) press(1, 0, 8'(i));
    for (int i = 0; i < 6; i++) press(0, 1, 8'h00);
    check("wrap_empty", empty, 1);
    for (int i = 10; i < 14; i++) press(1, 0, 8'(i));
    check("wrap_count", count, 4);
    for (int i = 10; i < 14; i++) begin
      check($sformatf("wrap_rd%0d", i), r_data, i);
      press(0, 1, 8'h00);
    end
    check("wrap_end", empty, 1);

    // 6 reset mid-press
    do_reset();
    press(0, 1, 8'h00);
    for (int i = 0; i < 3; i++) press(1, 0, 8'(8'h20 + i));
    check("mid_pre_count", count, 3);
    check("mid_pre_udf", udf, 1);
    data = 8'h77;
    button_wrd = 1'b1;
    cyc(3);
    #5;
    clr = 1'b1;
    #1;
    check("mid_empty", empty, 1);
    check("mid_count", count, 0);
    check("mid_flags", {ovf, udf}, 0);
    @(negedge clk);
    clr = 1'b0;
    snap = nw;
    cyc(4);
    check("mid_nopulse", nw - snap, 0);
    cyc(10);
    check("mid_pulse", nw - snap, 1);
    check("mid_count1", count, 1);
    check("mid_rdata", r_data, 8'h77);
    button_wrd = 1'b0;
    cyc(12);
    check("mid_release", nw - snap, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
